// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Consumes a byte stream framed as
//   LEN_HI, LEN_LO, 4*N data bytes (big-endian words), XOR checksum byte.
//   Each assembled word is written to consecutive instruction-memory word
//   addresses. The processor is held in reset until a frame loads with a
//   matching checksum.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   start_i          one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid_i       in_data_i holds a stream byte
//   in_data_i        stream byte
//   in_ready_o       loader accepts a byte this cycle
//   mem_we_o         instruction memory write strobe (one cycle per word)
//   mem_addr_o       word-aligned byte address of the write
//   mem_wdata_o      word to write
//   cpu_reset_o      hold processor in reset
//   done_o           frame loaded, checksum matched (level)
//   error_o          length overflow or checksum mismatch (level)
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH+1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  // One bit wider than the address so a full-memory frame counts to 2^AW.
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            csum_q, csum_d;
  // Holds the first three bytes of the word being assembled.
  logic [23:0]           shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        accept;
  logic [15:0] len_rx;

  assign in_ready_o = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept     = in_valid_i && in_ready_o;
  assign len_rx     = {len_hi_q, in_data_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    shift_d    = shift_q;
    we_d       = 1'b0;   // strobe: never held across a stall
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_LEN_HI;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_rst_d  = 1'b1;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data_i;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if (32'(len_rx) > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data_i};
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {shift_q, in_data_i};
            addr_d     = {word_cnt_q[ADDR_WIDTH-1:0], 2'b00};
            word_cnt_d = word_cnt_q + 1'b1;
            if (32'(word_cnt_q) + 32'd1 == 32'(len_q))
              state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          if (in_data_i == csum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_reset_o = cpu_rst_q;
  assign done_o      = done_q;
  assign error_o     = err_q;

endmodule
